// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Receives a framed program image over an 8N1 UART line and writes it,
//   one 32-bit little-endian word at a time, into the instruction ROM.
//   The core stays in reset until a complete image with a matching
//   checksum has been written.
//
//   Frame: 0xA5, N[7:0], N[15:8], N*4 data bytes, CHK (XOR of data bytes).
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   rx         UART serial input (idle high, LSB first)
//   wr_en      one-cycle ROM write strobe
//   wr_addr    ROM word address
//   wr_data    ROM write data
//   core_hold  1 = keep the core in reset
//   boot_done  sticky, a valid image has been loaded
//   boot_err   the last frame failed (framing, length or checksum)
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  // Largest legal word count (ROM capacity), widened so 2^16 cannot overflow.
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  // ---------------- bit-level receiver ----------------
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;

  bit_state_t    bstate;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_valid;
  logic          frame_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      bstate     <= B_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (bstate)
        B_IDLE: begin
          if (rx_prev && !rx_sync) begin
            bstate <= B_START;
            cnt    <= '0;
          end
        end
        B_START: begin
          // Mid-bit check of the start bit; a high level here was a glitch.
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            bstate  <= rx_sync ? B_IDLE : B_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) bstate <= B_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_STOP: begin
          // Back to idle right after the stop sample so a following start
          // edge that arrives early in the stop period is still caught.
          if (cnt == FULL_M1) begin
            cnt    <= '0;
            bstate <= B_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  // ---------------- frame protocol ----------------
  typedef enum logic [2:0] {
    P_WAIT_SYNC, P_LEN_LO, P_LEN_HI, P_DATA, P_CHECK, P_DONE
  } proto_state_t;

  proto_state_t pstate;
  logic [7:0]   len_lo;
  logic [15:0]  n_words;
  logic [15:0]  word_cnt;
  logic [1:0]   byte_idx;
  logic [7:0]   chk;
  logic [15:0]  len_word;

  assign len_word = {shreg, len_lo};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pstate    <= P_WAIT_SYNC;
      len_lo    <= '0;
      n_words   <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      chk       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      core_hold <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      // Address advances the cycle after the strobe so it is stable during it.
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      case (pstate)
        P_WAIT_SYNC: begin
          if (byte_valid && shreg == 8'hA5) begin
            pstate   <= P_LEN_LO;
            boot_err <= 1'b0;
            chk      <= '0;
            wr_addr  <= '0;
          end
        end
        P_LEN_LO: begin
          if (byte_valid) begin
            len_lo <= shreg;
            pstate <= P_LEN_HI;
          end
        end
        P_LEN_HI: begin
          if (byte_valid) begin
            n_words  <= len_word;
            word_cnt <= '0;
            byte_idx <= '0;
            if ({1'b0, len_word} > CAP) begin
              boot_err <= 1'b1;
              pstate   <= P_WAIT_SYNC;
            end else if (len_word == 16'd0) begin
              pstate <= P_CHECK;
            end else begin
              pstate <= P_DATA;
            end
          end
        end
        P_DATA: begin
          if (byte_valid) begin
            wr_data[{byte_idx, 3'b000} +: 8] <= shreg;
            chk      <= chk ^ shreg;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              wr_en    <= 1'b1;
              word_cnt <= word_cnt + 1'b1;
            end
          end else if (wr_en && word_cnt == n_words) begin
            // Leave only after the final strobe so wr_en never shows outside DATA.
            pstate <= P_CHECK;
          end
        end
        P_CHECK: begin
          if (byte_valid) begin
            if (shreg == chk) begin
              boot_done <= 1'b1;
              core_hold <= 1'b0;
              pstate    <= P_DONE;
            end else begin
              boot_err <= 1'b1;
              pstate   <= P_WAIT_SYNC;
            end
          end
        end
        P_DONE:  ;
        default: pstate <= P_WAIT_SYNC;
      endcase
      // A broken byte aborts any frame in progress.
      if (frame_err && pstate != P_WAIT_SYNC && pstate != P_DONE) begin
        boot_err <= 1'b1;
        pstate   <= P_WAIT_SYNC;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader (CLKS_PER_BIT=8, ADDR_W=4).
// Stimulus pushes each expected ROM write into a queue as the word is sent;
// an independent monitor pops and compares on every wr_en.
module tb_uart_boot_loader;
  localparam int CPB = 8;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          core_hold, boot_done, boot_err;

  int checks = 0;
  int errors = 0;
  logic [AW+31:0] exp_q[$];

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .core_hold(core_hold), .boot_done(boot_done),
    .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (reset && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write", wr_addr, wr_data);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   wr_addr, wr_data, e[AW+31:32], e[31:0]);
        end else begin
          $display("write addr=%0h data=%08h ok", wr_addr, wr_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic check_status(input string name, input logic done, input logic err, input logic hold);
    check({name, "_boot_done"}, 64'(boot_done), 64'(done));
    check({name, "_boot_err"},  64'(boot_err),  64'(err));
    check({name, "_core_hold"}, 64'(core_hold), 64'(hold));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_wr_en"},   64'(wr_en),   64'(0));
    check({name, "_wr_addr"}, 64'(wr_addr), 64'(0));
    check({name, "_wr_data"}, 64'(wr_data), 64'(0));
    check_status(name, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w);
    exp_q.push_back({addr, w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  // Two-word image; the good checksum is 78^56^34^12^EF^BE^AD^DE = 0x2A.
  task automatic send_image(input logic [7:0] chk_byte);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(4'd0, 32'h12345678);
    send_word(4'd1, 32'hDEADBEEF);
    send_byte(chk_byte, 1'b1);
    repeat (10) @(posedge clk);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    // Reset and idle line: no activity for 1000 cycles.
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (1000) @(posedge clk);
    #1 check_reset_values("reset");

    // Bad checksum: both words are written but the core is not released.
    send_image(8'h67);
    check_status("bad_chk", 1'b0, 1'b1, 1'b1);
    // Resending a correct image clears the error and releases the core.
    send_image(8'h2A);
    check_status("good", 1'b1, 1'b0, 1'b0);

    // Length overflow: N=17 > 16; following data is ignored.
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(posedge clk);
    check_status("len_ovf", 1'b0, 1'b1, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    check_status("len_ovf_after", 1'b0, 1'b1, 1'b1);

    // Framing error inside DATA aborts the frame.
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b0);
    check_status("frame_err", 1'b0, 1'b1, 1'b1);
    // Short low glitch must not become a byte; then a zero-length image.
    rx = 1'b0;
    repeat (2) @(posedge clk);
    rx = 1'b1;
    repeat (40) @(posedge clk);
    check_status("glitch", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(posedge clk);
    check_status("zero_len", 1'b1, 1'b0, 1'b0);

    // Reset mid-frame discards everything; a fresh image loads from addr 0.
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check_reset_values("mid_reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    send_image(8'h2A);
    check_status("reload", 1'b1, 1'b0, 1'b0);
    // Bytes after DONE are ignored: no writes, status unchanged.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    repeat (10) @(posedge clk);
    check_status("after_done", 1'b1, 1'b0, 1'b0);

    check("pending_writes", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
